// File: rtl/mult_sched_pkg.sv
// Shared types and widths for the round-robin multiplier scheduler.
// Optional statistics counter is enabled with MULT_SCHED_STATS_EN.
package mult_sched_pkg;

  localparam int MULT_DATA_W = 8;
  localparam int MULT_CNT_W  = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } mult_sched_state_t;

  typedef struct packed {
    logic [MULT_DATA_W-1:0] a;
    logic [MULT_DATA_W-1:0] b;
  } mult_ops_t;

endpackage

// File: rtl/mult_rr_arbiter.sv
// Round-robin arbiter: first set request at or after ptr, wrapping modulo NREQ.
// Purely combinational; one-hot grant plus encoded index.
module mult_rr_arbiter #(
  parameter int NREQ = 4,
  parameter int ID_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [ID_W-1:0] ptr,
  output logic [NREQ-1:0] gnt,
  output logic [ID_W-1:0] gnt_idx,
  output logic            gnt_vld
);

  logic [ID_W:0] j;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_vld = 1'b0;
    j       = '0;
    for (int k = 0; k < NREQ; k++) begin
      j = {1'b0, ptr} + (ID_W+1)'(k);
      if (j >= (ID_W+1)'(NREQ)) j = j - (ID_W+1)'(NREQ);
      if (!gnt_vld && req[j[ID_W-1:0]]) begin
        gnt_vld               = 1'b1;
        gnt_idx               = j[ID_W-1:0];
        gnt[j[ID_W-1:0]]      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/multiplier_int8.sv
// Combinational int8 multiplier, product truncated to 8 bits (sign-agnostic).
// Zero latency; no flow control.
module multiplier_int8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] y
);

  assign y = a * b;

endmodule

// File: rtl/mult_rr_scheduler.sv
// Shares one multiplier_int8 among NREQ requesters: IDLE grant, BUSY compute, DONE hold (3 cycles/op).
// DONE holds the response and blocks new grants while rsp_ready=0; MULT_SCHED_STATS_EN adds op_count.
module mult_rr_scheduler
  import mult_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int ID_W = $clog2(NREQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*8-1:0]       req_a,
  input  logic [NREQ*8-1:0]       req_b,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic [MULT_DATA_W-1:0]  rsp_y
`ifdef MULT_SCHED_STATS_EN
  ,
  output logic [MULT_CNT_W-1:0]   op_count
`endif
);

  mult_sched_state_t      state;
  logic [ID_W-1:0]        ptr;
  logic [ID_W-1:0]        op_id;
  mult_ops_t              ops;
  logic [NREQ-1:0]        gnt;
  logic [ID_W-1:0]        gnt_idx;
  logic                   gnt_vld;
  logic [MULT_DATA_W-1:0] prod;
  logic [ID_W-1:0]        ptr_nxt;

  mult_rr_arbiter #(.NREQ(NREQ), .ID_W(ID_W)) u_arb (
    .req     (req_valid),
    .ptr     (ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
  );

  multiplier_int8 u_mul (
    .a (ops.a),
    .b (ops.b),
    .y (prod)
  );

  // Grants are only visible in IDLE so DONE backpressure stalls every requester.
  assign req_ready = (state == ST_IDLE) ? gnt : '0;
  assign rsp_valid = (state == ST_DONE);
  assign ptr_nxt   = (op_id == ID_W'(NREQ-1)) ? '0 : op_id + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      ptr    <= '0;
      op_id  <= '0;
      ops    <= '0;
      rsp_id <= '0;
      rsp_y  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (gnt_vld) begin
            ops.a <= req_a[{gnt_idx, 3'b000} +: 8];
            ops.b <= req_b[{gnt_idx, 3'b000} +: 8];
            op_id <= gnt_idx;
            state <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          rsp_y  <= prod;
          rsp_id <= op_id;
          ptr    <= ptr_nxt;
          state  <= ST_DONE;
        end
        ST_DONE: begin
          if (rsp_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef MULT_SCHED_STATS_EN
  logic [MULT_CNT_W-1:0] op_count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count_q <= '0;
    end else if (state == ST_DONE && rsp_ready && op_count_q != '1) begin
      op_count_q <= op_count_q + 1'b1;
    end
  end

  assign op_count = op_count_q;
`endif

endmodule

// File: tb/tb_mult_rr_scheduler.sv
// Directed self-checking bench for mult_rr_scheduler (NREQ=4); stats checks need MULT_SCHED_STATS_EN.
module tb_mult_rr_scheduler;

  localparam int NREQ = 4;
  localparam int ID_W = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*8-1:0] req_a;
  logic [NREQ*8-1:0] req_b;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [ID_W-1:0]   rsp_id;
  logic [7:0]        rsp_y;
`ifdef MULT_SCHED_STATS_EN
  logic [15:0]       op_count;
`endif

  int checks   = 0;
  int failures = 0;

  mult_rr_scheduler #(.NREQ(NREQ), .ID_W(ID_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_y     (rsp_y)
`ifdef MULT_SCHED_STATS_EN
    ,
    .op_count  (op_count)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Single requester idx runs one full operation; caller sits at a negedge in IDLE with rsp_ready=1.
  task automatic op(input int idx, input logic [7:0] a, input logic [7:0] b,
                    input logic [7:0] y, input string tag);
    req_valid          = 4'(1 << idx);
    req_a[8*idx +: 8]  = a;
    req_b[8*idx +: 8]  = b;
    #1 check({tag, "_ready"}, 32'(req_ready), 32'(1 << idx));
    tick();
    req_valid = '0;
    #1 check({tag, "_busy_vld"}, 32'(rsp_valid), 32'd0);
    tick();
    #1;
    check({tag, "_vld"}, 32'(rsp_valid), 32'd1);
    check({tag, "_id"},  32'(rsp_id),    32'(idx));
    check({tag, "_y"},   32'(rsp_y),     32'(y));
    tick();
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    #1;
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_vld",   32'(rsp_valid), 32'd0);
    check("rst_id",    32'(rsp_id),    32'd0);
    check("rst_y",     32'(rsp_y),     32'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // single request and truncation
    op(0, 8'd3,   8'd5,   8'd15,  "single");
    op(1, 8'h10,  8'h11,  8'h10,  "trunc_10x11");
    op(2, 8'hFF,  8'hFF,  8'h01,  "trunc_ffxff");

    // fairness from a freshly reset pointer, all requesters always valid
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      req_a[8*i +: 8] = 8'(i + 2);
      req_b[8*i +: 8] = 8'd3;
    end
    req_valid = 4'b1111;
    for (int g = 0; g < 5; g++) begin
      #1 check("fair_grant", 32'(req_ready), 32'(1 << (g % 4)));
      tick();
      #1 check("fair_busy_ready", 32'(req_ready), 32'd0);
      tick();
      #1;
      check("fair_vld",        32'(rsp_valid), 32'd1);
      check("fair_id",         32'(rsp_id),    32'(g % 4));
      check("fair_y",          32'(rsp_y),     32'(3 * ((g % 4) + 2)));
      check("fair_done_ready", 32'(req_ready), 32'd0);
      tick();
    end
    req_valid = '0;

    // backpressure: 7*9=0x3F held for 5 cycles, requester 3 stalled meanwhile
    rsp_ready        = 1'b0;
    req_valid        = 4'b0100;
    req_a[16 +: 8]   = 8'd7;
    req_b[16 +: 8]   = 8'd9;
    #1 check("bp_grant", 32'(req_ready), 32'b0100);
    tick();
    req_valid = 4'b1000;
    #1 check("bp_busy_ready", 32'(req_ready), 32'd0);
    tick();
    for (int c = 0; c < 5; c++) begin
      #1;
      check("bp_vld",   32'(rsp_valid), 32'd1);
      check("bp_id",    32'(rsp_id),    32'd2);
      check("bp_y",     32'(rsp_y),     32'h3F);
      check("bp_ready", 32'(req_ready), 32'd0);
      tick();
    end
    rsp_ready = 1'b1;
    req_valid = '0;
    tick();
    #1 check("bp_complete", 32'(rsp_valid), 32'd0);

    // asynchronous reset while BUSY
    @(negedge clk);
    req_valid       = 4'b0001;
    req_a[0 +: 8]   = 8'd3;
    req_b[0 +: 8]   = 8'd5;
    #1 check("rb_grant", 32'(req_ready), 32'b0001);
    tick();
    req_valid = '0;
    #2 rst_n = 1'b0;
    #1;
    check("rb_vld", 32'(rsp_valid), 32'd0);
    check("rb_id",  32'(rsp_id),    32'd0);
    check("rb_y",   32'(rsp_y),     32'd0);
    tick();
    #1 check("rb_no_rsp", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    rst_n           = 1'b1;
    req_valid       = 4'b0110;
    req_a[8 +: 8]   = 8'd6;
    req_b[8 +: 8]   = 8'd7;
    #1 check("rb_first_grant", 32'(req_ready), 32'b0010);
    tick();
    req_valid = '0;
    tick();
    #1;
    check("rb_rsp_id", 32'(rsp_id), 32'd1);
    check("rb_rsp_y",  32'(rsp_y),  32'h2A);
    tick();

`ifdef MULT_SCHED_STATS_EN
    op(0, 8'd2, 8'd2, 8'd4, "st_a");
    op(3, 8'd4, 8'd4, 8'd16, "st_b");
    #1 check("stats_three", 32'(op_count), 32'd3);
    force dut.op_count_q = 16'hFFFE;
    #1 release dut.op_count_q;
    @(negedge clk);
    for (int n = 0; n < 3; n++) op(1, 8'd1, 8'd9, 8'd9, "st_sat");
    #1 check("stats_sat", 32'(op_count), 32'hFFFF);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
